rom_port_arbiter: RTL and testbench

- Shares the single asynchronous program-ROM read port (11-bit address, 29-bit word) between two requesters: the CPU instruction fetch stage (F) and the program-memory data-load path (D).
- Arbitrates one read per cycle, drives the ROM address, and registers the returned word back to the winning requester with a fixed 1-cycle latency.
- Supports a fetch flush so the CPU can discard an in-flight fetch on a branch, and provides a saturating conflict counter for performance observation.
- Sits between the CPU core and the ROM instance.

---
 rtl/rom_port_arbiter.sv | 131 +++++++++++++
 tb/tb_rom_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares the single asynchronous program-ROM read port between the CPU
// instruction fetch stage (F) and the program-memory data-load path (D).
// One read is granted per cycle. The ROM word is registered back to the
// winning requester one cycle later. When both sides compete, the grant
// alternates round-robin.
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   f_req/f_addr        fetch request and address, held until f_gnt
//   f_flush             drops the fetch request this cycle and discards the
//                       fetch response arriving this cycle
//   f_gnt               fetch granted this cycle (combinational)
//   f_valid/f_data      registered fetch response, 1-cycle valid pulse
//   d_req/d_addr        data-load request and address, held until d_gnt
//   d_gnt               data-load granted this cycle (combinational)
//   d_valid/d_data      registered data-load response, 1-cycle valid pulse
//   rom_addr/rom_data   ROM read port (address out, word in)
//   conflict_cnt        saturating count of cycles with both sides requesting
module rom_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 29,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  // Remembers which requester was served most recently.
  typedef enum logic {
    LAST_F = 1'b0,
    LAST_D = 1'b1
  } last_t;

  last_t last_grant, last_grant_next;

  logic fe;
  logic conflict;
  logic f_valid_q;
  logic d_valid_q;

  // A flushed fetch does not compete for the port.
  assign fe       = f_req & ~f_flush;
  assign conflict = fe & d_req;

  // Grant selection and ROM address mux. On a conflict, the side that was
  // not served last wins. Otherwise, the only requester wins.
  always_comb begin
    f_gnt           = 1'b0;
    d_gnt           = 1'b0;
    rom_addr        = '0;
    last_grant_next = last_grant;
    if (conflict) begin
      if (last_grant == LAST_D) begin
        f_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
    end else if (fe) begin
      f_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
    if (f_gnt) begin
      rom_addr        = f_addr;
      last_grant_next = LAST_F;
    end else if (d_gnt) begin
      rom_addr        = d_addr;
      last_grant_next = LAST_D;
    end
  end

  // Round-robin history. Reset to D so that F wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_D;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Response registers. The data registers capture only on a grant and
  // otherwise hold their value. The valid registers pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      f_data    <= '0;
      d_data    <= '0;
    end else begin
      f_valid_q <= f_gnt;
      d_valid_q <= d_gnt;
      if (f_gnt) begin
        f_data <= rom_data;
      end
      if (d_gnt) begin
        d_data <= rom_data;
      end
    end
  end

  // A flush raised while a fetch response is being presented discards that
  // response. Fetches cannot be granted during a flush cycle, so no response
  // can appear in the cycle after a flush.
  assign f_valid = f_valid_q & ~f_flush;
  assign d_valid = d_valid_q;

  // Conflict counter. It saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
// Drives rom_port_arbiter with directed scenarios and a long randomized run.
// Every cycle, the DUT is compared against a behavioural reference model.
// The ROM is modelled as an asynchronous lookup table. A narrow counter
// width makes the saturation behaviour reachable quickly.
module tb_rom_port_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 29;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_valid;
  logic [DATA_W-1:0] f_data;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [CNT_W-1:0]  conflict_cnt;

  logic [DATA_W-1:0] rom_mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  // Reference model state, as seen after the most recent clock edge.
  bit                m_d_served_last;
  int                m_conflicts;
  bit                m_f_due;
  bit                m_d_due;
  logic [DATA_W-1:0] m_f_word;
  logic [DATA_W-1:0] m_d_word;

  rom_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_flush     (f_flush),
    .f_gnt       (f_gnt),
    .f_valid     (f_valid),
    .f_data      (f_data),
    .d_req       (d_req),
    .d_addr      (d_addr),
    .d_gnt       (d_gnt),
    .d_valid     (d_valid),
    .d_data      (d_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .conflict_cnt(conflict_cnt)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Puts the model into its power-on state.
  task automatic modelReset();
    m_d_served_last = 1'b1;
    m_conflicts     = 0;
    m_f_due         = 1'b0;
    m_d_due         = 1'b0;
    m_f_word        = '0;
    m_d_word        = '0;
  endtask

  // Runs one clock cycle with the given inputs. It checks the combinational
  // outputs and the registered state against the model, then moves the model
  // forward by one edge.
  task automatic applyStimulus(input bit fr, input int fa, input bit ff,
                               input bit dr, input int da);
    bit                fe;
    bit                win_f;
    bit                win_d;
    logic [ADDR_W-1:0] fa_v;
    logic [ADDR_W-1:0] da_v;
    logic [ADDR_W-1:0] exp_addr;
    fa_v = ADDR_W'(fa);
    da_v = ADDR_W'(da);
    @(negedge clk);
    f_req   = fr;
    f_addr  = fa_v;
    f_flush = ff;
    d_req   = dr;
    d_addr  = da_v;
    #1;
    fe    = fr && !ff;
    win_f = fe && (!dr || m_d_served_last);
    win_d = dr && !win_f;
    exp_addr = win_f ? fa_v : (win_d ? da_v : '0);
    checkOutput("f_gnt", 32'(f_gnt), 32'(win_f));
    checkOutput("d_gnt", 32'(d_gnt), 32'(win_d));
    checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
    checkOutput("f_valid", 32'(f_valid), 32'(m_f_due && !ff));
    checkOutput("d_valid", 32'(d_valid), 32'(m_d_due));
    checkOutput("f_data", 32'(f_data), 32'(m_f_word));
    checkOutput("d_data", 32'(d_data), 32'(m_d_word));
    checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(m_conflicts));
    m_f_due = win_f;
    m_d_due = win_d;
    if (win_f) begin
      m_f_word        = rom_mem[fa_v];
      m_d_served_last = 1'b0;
    end
    if (win_d) begin
      m_d_word        = rom_mem[da_v];
      m_d_served_last = 1'b1;
    end
    if (fe && dr && m_conflicts < CNT_MAX) m_conflicts++;
  endtask

  // Asserts reset in the middle of a cycle, with requests active, and
  // verifies that state clears without a clock edge. Requests are dropped
  // before the release so that the first edge after reset is idle.
  task automatic midCycleReset();
    #2;
    f_req = 1'b1;
    d_req = 1'b1;
    f_flush = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_f_valid", 32'(f_valid), 32'd0);
    checkOutput("rst_d_valid", 32'(d_valid), 32'd0);
    checkOutput("rst_f_data", 32'(f_data), 32'd0);
    checkOutput("rst_d_data", 32'(d_data), 32'd0);
    checkOutput("rst_cnt", 32'(conflict_cnt), 32'd0);
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("rst_hold_f_valid", 32'(f_valid), 32'd0);
    checkOutput("rst_hold_d_valid", 32'(d_valid), 32'd0);
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = DATA_W'($urandom);
    rom_mem[0]  = 29'h01f040ff;
    rom_mem[1]  = 29'h01000005;
    rom_mem[20] = 29'h170e0000;
    modelReset();
    rst_n   = 1'b0;
    f_req   = 1'b0;
    f_addr  = '0;
    f_flush = 1'b0;
    d_req   = 1'b0;
    d_addr  = '0;
    $display("[TB] starting rom_port_arbiter bench");

    // Reset from time zero, with both requesters active during reset.
    @(negedge clk);
    midCycleReset();

    // The first conflict after reset goes to F.
    applyStimulus(1, 3, 0, 1, 9);
    applyStimulus(0, 0, 0, 1, 9);
    applyStimulus(0, 0, 0, 0, 0);

    // Single fetch of address 1.
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Contention for six cycles. Grants alternate and the counter saturates.
    midCycleReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 10 + i, 0, 1, 200 + i);
    applyStimulus(0, 0, 0, 0, 0);

    // Flush: fetch 4 is granted, then flushed while a D grant happens.
    applyStimulus(1, 4, 0, 0, 0);
    applyStimulus(1, 4, 1, 1, 7);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Streaming fetch of addresses 0 to 20.
    for (int a = 0; a <= 20; a++) applyStimulus(1, a, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Saturation for five cycles, followed by a mid-cycle reset.
    for (int i = 0; i < 5; i++) applyStimulus(1, 30 + i, 0, 1, 40 + i);
    midCycleReset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 99) < 65, int'($urandom_range(0, 2047)),
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 55, int'($urandom_range(0, 2047)));
      if ($urandom_range(0, 99) == 0) midCycleReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
